// File: rtl/mux4_scan_ctrl_if.sv
// Bundle of the scan request, mux select/sample and snapshot handshake signals.
// The master side is the scan controller; the slave side is the mux and the consumer.
interface mux4_scan_ctrl_if;
    logic       start;
    logic [3:0] ch_mask;
    logic       Y;
    logic       S0;
    logic       S1;
    logic       busy;
    logic [3:0] snap;
    logic       snap_valid;
    logic       snap_ready;

    modport master (
        input  start, ch_mask, Y, snap_ready,
        output S0, S1, busy, snap, snap_valid
    );

    modport slave (
        output start, ch_mask, Y, snap_ready,
        input  S0, S1, busy, snap, snap_valid
    );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// Round-robin scan of the enabled mux4 channels with a settle dwell per channel;
// the packed samples are offered as a snapshot over a valid/ready handshake.
module mux4_scan_ctrl #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux4_scan_ctrl_if.master  bus
);

    typedef enum logic [1:0] {IDLE, DWELL, HOLD} state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_mask, w_mask_nxt;
    logic [3:0]       r_buf, w_buf_nxt;
    logic [3:0]       r_snap, w_snap_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_valid, w_valid_nxt;
    logic [2:0]       w_first;
    logic [2:0]       w_next;

    // Returns {found, index} of the lowest enabled channel strictly above cur
    // (cur = -1 gives the lowest enabled channel overall).
    function automatic logic [2:0] next_enabled(input logic [3:0] m, input int cur);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > cur)) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    assign w_first = next_enabled(bus.ch_mask, -1);
    assign w_next  = next_enabled(r_mask, int'(r_sel));

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_buf_nxt   = r_buf;
        w_snap_nxt  = r_snap;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        unique case (r_state)
            IDLE: begin
                if (bus.start && (bus.ch_mask != 4'b0000)) begin
                    w_mask_nxt  = bus.ch_mask;
                    w_buf_nxt   = 4'b0000;
                    w_sel_nxt   = w_first[1:0];
                    w_cnt_nxt   = '0;
                    w_state_nxt = DWELL;
                end
            end
            DWELL: begin
                if (r_cnt == CNT_W'(SETTLE)) begin
                    w_buf_nxt[r_sel] = bus.Y;
                    w_cnt_nxt        = '0;
                    if (w_next[2]) begin
                        w_sel_nxt = w_next[1:0];
                    end else begin
                        w_snap_nxt  = w_buf_nxt;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (r_valid && bus.snap_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mask  <= 4'b0000;
            r_buf   <= 4'b0000;
            r_snap  <= 4'b0000;
            r_sel   <= 2'b00;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_buf   <= w_buf_nxt;
            r_snap  <= w_snap_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign bus.S0         = r_sel[0];
    assign bus.S1         = r_sel[1];
    assign bus.busy       = (r_state != IDLE);
    assign bus.snap       = r_snap;
    assign bus.snap_valid = r_valid;

endmodule
